pipe_hazard_sched: RTL and testbench

//  Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.

---
 rtl/pipe_hazard_sched.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched
// Pipeline-register sequencing for the 5-stage MIPS core.
// Owns the MULT/DIV busy timer and generates the stall, bubble and flush enables.
// Also selects the PC source when an exception or ERET commits at MEM.
module pipe_hazard_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        load_use_hz,
    input  logic        id_md_use,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        exc_req,
    input  logic        eret_req,
    output logic        stall,
    output logic        bubble_idex,
    output logic        flush_all,
    output logic [1:0]  pc_sel,
    output logic        md_busy,
    output logic        md_done,
    output logic        md_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      cnt_q, cnt_d;

    logic             flush;
    logic             raw_stall;
    logic             stall_int;

    // Every flop resets asynchronously so a mid-operation reset kills the MULT/DIV immediately.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start the timer from IDLE and count it down while BUSY.
    // A start that coincides with a flush belongs to a squashed instruction, so it is dropped.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = stall_int ? cnt_q + 32'd1 : cnt_q;
        unique case (state_q)
            IDLE: begin
                if (md_start && !flush) begin
                    state_d = BUSY;
                    timer_d = md_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (md_start && !flush) begin
                    err_d = 1'b1;
                end
                if (timer_q == TIMER_ONE) begin
                    state_d = IDLE;
                    timer_d = '0;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Output logic: a flush overrides any stall and also forces the ID/EX bubble.
    always_comb begin
        flush     = exc_req | eret_req;
        raw_stall = load_use_hz | (id_md_use & ((state_q == BUSY) | md_start));
        stall_int = raw_stall & ~flush;
        if (exc_req) begin
            pc_sel = 2'b01;
        end else if (eret_req) begin
            pc_sel = 2'b10;
        end else begin
            pc_sel = 2'b00;
        end
    end

    assign stall       = stall_int;
    assign bubble_idex = stall_int | flush;
    assign flush_all   = flush;
    assign md_busy     = (state_q == BUSY);
    assign md_done     = done_q;
    assign md_err      = err_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// tb_pipe_hazard_sched
// Directed bench for pipe_hazard_sched.
// Inputs change 2 time units after each rising edge, and outputs are sampled 1 unit later.
module tb_pipe_hazard_sched;

    logic        clk;
    logic        reset;
    logic        load_use_hz;
    logic        id_md_use;
    logic        md_start;
    logic        md_is_div;
    logic        exc_req;
    logic        eret_req;
    logic        stall;
    logic        bubble_idex;
    logic        flush_all;
    logic [1:0]  pc_sel;
    logic        md_busy;
    logic        md_done;
    logic        md_err;
    logic [31:0] stall_cnt;

    int total;
    int bad;

    pipe_hazard_sched #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .CLK        (clk),
        .reset      (reset),
        .load_use_hz(load_use_hz),
        .id_md_use  (id_md_use),
        .md_start   (md_start),
        .md_is_div  (md_is_div),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .stall      (stall),
        .bubble_idex(bubble_idex),
        .flush_all  (flush_all),
        .pc_sel     (pc_sel),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_err     (md_err),
        .stall_cnt  (stall_cnt)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; counts and reports a mismatch
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next drive point, 2 units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Directed sequence
    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        load_use_hz = 1'b0;
        id_md_use   = 1'b0;
        md_start    = 1'b0;
        md_is_div   = 1'b0;
        exc_req     = 1'b0;
        eret_req    = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        #1;
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_done", 32'(md_done), 32'd0);
        chk("rst_err", 32'(md_err), 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        chk("rst_pcsel", 32'(pc_sel), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // MULT: busy in cycles 1..5, done in cycle 6 only
        md_start  = 1'b1;
        md_is_div = 1'b0;
        step();
        md_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("mult_busy_c%0d", i), 32'(md_busy), 32'd1);
            chk($sformatf("mult_done_c%0d", i), 32'(md_done), 32'd0);
            step();
        end
        #1;
        chk("mult_busy_c6", 32'(md_busy), 32'd0);
        chk("mult_done_c6", 32'(md_done), 32'd1);
        step();
        #1;
        chk("mult_done_c7", 32'(md_done), 32'd0);

        // DIV with id_md_use held: stall in cycles 0..10 (11 edges), then released
        id_md_use = 1'b1;
        md_start  = 1'b1;
        md_is_div = 1'b1;
        #1;
        chk("div_stall_c0", 32'(stall), 32'd1);
        step();
        md_start  = 1'b0;
        md_is_div = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk($sformatf("div_stall_c%0d", i), 32'(stall), 32'd1);
            chk($sformatf("div_busy_c%0d", i), 32'(md_busy), 32'd1);
            step();
        end
        #1;
        chk("div_stall_c11", 32'(stall), 32'd0);
        chk("div_busy_c11", 32'(md_busy), 32'd0);
        chk("div_done_c11", 32'(md_done), 32'd1);
        chk("div_cnt", stall_cnt, 32'd11);
        id_md_use = 1'b0;

        // Load-use under an exception: flush wins, no stall counted
        load_use_hz = 1'b1;
        exc_req     = 1'b1;
        #1;
        chk("exc_stall", 32'(stall), 32'd0);
        chk("exc_bubble", 32'(bubble_idex), 32'd1);
        chk("exc_flush", 32'(flush_all), 32'd1);
        chk("exc_pcsel", 32'(pc_sel), 32'd1);
        step();
        exc_req = 1'b0;
        #1;
        chk("exc_cnt", stall_cnt, 32'd11);
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_bubble", 32'(bubble_idex), 32'd1);
        chk("lu_flush", 32'(flush_all), 32'd0);
        step();
        load_use_hz = 1'b0;
        #1;
        chk("lu_cnt", stall_cnt, 32'd12);

        // Second start while busy: ignored, original schedule kept, sticky error
        md_start = 1'b1;
        step();
        #1;
        chk("dbl_busy_c1", 32'(md_busy), 32'd1);
        chk("dbl_err_c1", 32'(md_err), 32'd0);
        step();
        md_start = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            #1;
            chk($sformatf("dbl_busy_c%0d", i), 32'(md_busy), 32'd1);
            chk($sformatf("dbl_err_c%0d", i), 32'(md_err), 32'd1);
            step();
        end
        #1;
        chk("dbl_busy_c6", 32'(md_busy), 32'd0);
        chk("dbl_done_c6", 32'(md_done), 32'd1);
        chk("dbl_err_c6", 32'(md_err), 32'd1);
        step();

        // Async reset mid-BUSY, with the timer at 3
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        step();
        step();
        #1;
        chk("pre_rst_busy", 32'(md_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(md_busy), 32'd0);
        chk("arst_done", 32'(md_done), 32'd0);
        chk("arst_err", 32'(md_err), 32'd0);
        chk("arst_cnt", stall_cnt, 32'd0);
        #3;
        reset = 1'b0;
        step();
        #1;
        chk("post_rst_busy", 32'(md_busy), 32'd0);

        // Start coinciding with ERET: dropped, no error, EPC selected
        md_start = 1'b1;
        eret_req = 1'b1;
        #1;
        chk("eret_pcsel", 32'(pc_sel), 32'd2);
        chk("eret_flush", 32'(flush_all), 32'd1);
        step();
        md_start = 1'b0;
        eret_req = 1'b0;
        #1;
        chk("eret_busy", 32'(md_busy), 32'd0);
        chk("eret_err", 32'(md_err), 32'd0);

        // Counter wrap from all-ones
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        chk("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
        load_use_hz = 1'b1;
        step();
        load_use_hz = 1'b0;
        #1;
        chk("wrap_cnt", stall_cnt, 32'd0);

        // Exception and ERET together: exception vector wins
        exc_req  = 1'b1;
        eret_req = 1'b1;
        #1;
        chk("both_pcsel", 32'(pc_sel), 32'd1);
        chk("both_stall", 32'(stall), 32'd0);
        step();
        exc_req  = 1'b0;
        eret_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #20000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
